sblk_row_dispatch: RTL and testbench

Front-end dispatcher for a row of superblocks. It accepts one activation stream and one instruction stream from the row controller, and fans them out to `N_ROW` superblock lanes using a per-transfer row mask: unicast, multicast or broadcast. Each lane has its own buffering and backpressure. The block tracks per-lane busy status and signals completion of each issued instruction group. It replaces direct per-row wiring between controller and superblocks with a single masked interface.

---
 rtl/sblk_row_pkg.sv | 10 +
 rtl/sblk_row_fifo.sv | 49 ++++
 rtl/sblk_row_dispatch.sv | 109 ++++++++++
 tb/tb_sblk_row_dispatch.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sblk_row_pkg.sv
// sblk_row_pkg: shared state type, lane slice helper and default widths for the row dispatcher
package sblk_row_pkg;
  localparam int DEF_N_ROW = 8;
  localparam int DEF_WID_ACT = 16;
  localparam int DEF_WID_INST = 14;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  function automatic int lane_lo(input int lane, input int wid);
    return lane * wid;
  endfunction
endpackage

// File: rtl/sblk_row_fifo.sv
// sblk_row_fifo: show-ahead FIFO with a registered head word, valid and full flags
module sblk_row_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         vld_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push, pop;
  always_comb begin
    push = push_i && !full_o;
    pop = pop_i && vld_o;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din_i;
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      dout_o <= '0;
      vld_o <= 1'b0;
      full_o <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      dout_o <= mem_d[rd_d];
      vld_o <= cnt_d != '0;
      full_o <= cnt_d == (AW+1)'(DEPTH);
    end
  end
endmodule

// File: rtl/sblk_row_dispatch.sv
// sblk_row_dispatch: masked fan-out of activation/instruction streams to N_ROW lanes; SBLK_ROW_DISPATCH_PERF_EN builds stall counters
module sblk_row_dispatch
  import sblk_row_pkg::*;
#(
  parameter int N_ROW = DEF_N_ROW,
  parameter int WID_ACT = DEF_WID_ACT,
  parameter int WID_INST = DEF_WID_INST,
  parameter int ACT_DEPTH = 4,
  parameter int WID_PERF = 32
) (
  input  logic                      clk_h,
  input  logic                      rst,
  input  logic [2*WID_ACT-1:0]       s_act_data,
  input  logic [N_ROW-1:0]           s_act_mask,
  input  logic                      s_act_vld,
  output logic                      s_act_rdy,
  output logic [2*WID_ACT*N_ROW-1:0] act_data_out,
  output logic [N_ROW-1:0]           act_data_out_vld,
  input  logic [N_ROW-1:0]           act_data_out_req,
  input  logic [WID_INST-1:0]        s_inst_data,
  input  logic [N_ROW-1:0]           s_inst_mask,
  input  logic                      s_inst_vld,
  output logic                      s_inst_rdy,
  output logic [WID_INST*N_ROW-1:0]  inst_data_out,
  output logic [N_ROW-1:0]           inst_en_out,
  input  logic [N_ROW-1:0]           status_sblk,
  output logic [N_ROW-1:0]           row_busy,
  output logic                      all_done,
  output logic [WID_PERF-1:0]        perf_act_stall,
  output logic [WID_PERF-1:0]        perf_inst_stall
);
  localparam int WA = 2 * WID_ACT;
  logic [N_ROW-1:0] full, push, pop, mask_q, busy_nx;
  logic [WID_INST-1:0] data_q;
  logic blank_q;
  state_t state_q;
  assign s_act_rdy = ~|(s_act_mask & full);
  assign push = {N_ROW{s_act_vld && s_act_rdy}} & s_act_mask;
  assign pop = act_data_out_vld & act_data_out_req;
  assign s_inst_rdy = state_q == IDLE;
  assign busy_nx = row_busy & status_sblk;
  for (genvar r = 0; r < N_ROW; r++) begin : g_lane
    localparam int LO = lane_lo(r, WA);
    sblk_row_fifo #(.W(WA), .DEPTH(ACT_DEPTH)) u_fifo (
      .clk(clk_h),
      .rst(rst),
      .push_i(push[r]),
      .din_i(s_act_data),
      .pop_i(pop[r]),
      .dout_o(act_data_out[LO +: WA]),
      .vld_o(act_data_out_vld[r]),
      .full_o(full[r])
    );
  end
  always_ff @(posedge clk_h) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q <= '0;
      data_q <= '0;
      blank_q <= 1'b0;
      inst_en_out <= '0;
      inst_data_out <= '0;
      row_busy <= '0;
      all_done <= 1'b0;
    end else begin
      inst_en_out <= '0;
      all_done <= 1'b0;
      case (state_q)
        IDLE: if (s_inst_vld && |s_inst_mask) begin
          mask_q <= s_inst_mask;
          data_q <= s_inst_data;
          state_q <= ISSUE;
        end
        ISSUE: if (~|(status_sblk & mask_q)) begin
          inst_en_out <= mask_q;
          row_busy <= mask_q;
          blank_q <= 1'b1;
          state_q <= WAIT;
          for (int r = 0; r < N_ROW; r++)
            if (mask_q[r]) inst_data_out[lane_lo(r, WID_INST) +: WID_INST] <= data_q;
        end
        WAIT: if (blank_q) begin
          blank_q <= 1'b0;
        end else begin
          row_busy <= busy_nx;
          if (~|busy_nx) begin
            all_done <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef SBLK_ROW_DISPATCH_PERF_EN
  always_ff @(posedge clk_h) begin
    if (rst) begin
      perf_act_stall <= '0;
      perf_inst_stall <= '0;
    end else begin
      if (s_act_vld && !s_act_rdy && ~&perf_act_stall) perf_act_stall <= perf_act_stall + WID_PERF'(1);
      if (state_q == ISSUE && |(status_sblk & mask_q) && ~&perf_inst_stall) perf_inst_stall <= perf_inst_stall + WID_PERF'(1);
    end
  end
`else
  assign perf_act_stall = '0;
  assign perf_inst_stall = '0;
`endif
endmodule

// File: tb/tb_sblk_row_dispatch.sv
// tb_sblk_row_dispatch: directed stimulus checked every cycle against a queue-based model of the dispatcher
module tb_sblk_row_dispatch;
  localparam int N = 8;
  localparam int D = 4;
`ifdef SBLK_ROW_DISPATCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk_h = 1'b0;
  logic rst;
  logic [31:0] s_act_data;
  logic [7:0] s_act_mask, act_data_out_vld, act_data_out_req;
  logic s_act_vld, s_act_rdy;
  logic [255:0] act_data_out;
  logic [13:0] s_inst_data;
  logic [7:0] s_inst_mask, inst_en_out, status_sblk, row_busy;
  logic s_inst_vld, s_inst_rdy, all_done;
  logic [111:0] inst_data_out;
  logic [31:0] perf_act_stall, perf_inst_stall;
  sblk_row_dispatch dut (
    .clk_h(clk_h), .rst(rst),
    .s_act_data(s_act_data), .s_act_mask(s_act_mask), .s_act_vld(s_act_vld), .s_act_rdy(s_act_rdy),
    .act_data_out(act_data_out), .act_data_out_vld(act_data_out_vld), .act_data_out_req(act_data_out_req),
    .s_inst_data(s_inst_data), .s_inst_mask(s_inst_mask), .s_inst_vld(s_inst_vld), .s_inst_rdy(s_inst_rdy),
    .inst_data_out(inst_data_out), .inst_en_out(inst_en_out), .status_sblk(status_sblk),
    .row_busy(row_busy), .all_done(all_done),
    .perf_act_stall(perf_act_stall), .perf_inst_stall(perf_inst_stall)
  );
  always #5 clk_h = ~clk_h;
  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask
  task automatic push_wait(input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 12 && !ok; k++) begin
      @(negedge clk_h);
      if (s_act_rdy) ok = 1'b1;
      else tick();
    end
    chk(nm, ok, 1);
    tick();
  endtask
  logic [31:0] aq [N][$];
  logic [13:0] idata [N];
  logic [7:0] pmask, busy, m_en;
  logic [13:0] pdata;
  logic [31:0] pa, pi;
  bit armed = 1'b0, pend, fresh, m_done;
  always @(negedge clk_h) begin : model
    logic [7:0] ev;
    bit ardy, irdy;
    ardy = 1'b1;
    irdy = 1'b1;
    if (armed) begin
      ev = '0;
      for (int r = 0; r < N; r++) ev[r] = aq[r].size() != 0;
      chk("act_vld", act_data_out_vld, ev);
      for (int r = 0; r < N; r++)
        if (ev[r]) chk($sformatf("act_data[%0d]", r), act_data_out[r*32 +: 32], aq[r][0]);
      for (int r = 0; r < N; r++) if (s_act_mask[r] && aq[r].size() >= D) ardy = 1'b0;
      chk("act_rdy", s_act_rdy, ardy);
      irdy = !pend && busy == 0;
      chk("inst_rdy", s_inst_rdy, irdy);
      chk("inst_en", inst_en_out, m_en);
      chk("row_busy", row_busy, busy);
      chk("all_done", all_done, m_done);
      for (int r = 0; r < N; r++) chk($sformatf("inst_data[%0d]", r), inst_data_out[r*14 +: 14], idata[r]);
      chk("perf_act", perf_act_stall, pa);
      chk("perf_inst", perf_inst_stall, pi);
      if (all_done) done_cnt++;
    end
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        aq[r].delete();
        idata[r] = '0;
      end
      {pend, fresh, m_done} = '0;
      {pmask, busy, m_en, pdata, pa, pi} = '0;
      armed = 1'b1;
    end else if (armed) begin
      if (PERF && s_act_vld && !ardy && pa != '1) pa++;
      for (int r = 0; r < N; r++) if (aq[r].size() != 0 && act_data_out_req[r]) void'(aq[r].pop_front());
      if (s_act_vld && ardy)
        for (int r = 0; r < N; r++) if (s_act_mask[r]) aq[r].push_back(s_act_data);
      m_en = '0;
      m_done = 1'b0;
      if (irdy) begin
        if (s_inst_vld && s_inst_mask != 0) begin
          pend = 1'b1;
          pmask = s_inst_mask;
          pdata = s_inst_data;
        end
      end else if (pend) begin
        if ((status_sblk & pmask) == 0) begin
          m_en = pmask;
          busy = pmask;
          for (int r = 0; r < N; r++) if (pmask[r]) idata[r] = pdata;
          pend = 1'b0;
          fresh = 1'b1;
        end else if (PERF && pi != '1) pi++;
      end else if (fresh) begin
        fresh = 1'b0;
      end else begin
        busy = busy & status_sblk;
        if (busy == 0) m_done = 1'b1;
      end
    end
  end
  initial begin
    rst = 1'b1;
    s_act_data = '0; s_act_mask = '0; s_act_vld = 1'b0; act_data_out_req = '0;
    s_inst_data = '0; s_inst_mask = '0; s_inst_vld = 1'b0; status_sblk = '0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk_h);
    chk("rst_vld", act_data_out_vld, 0);
    chk("rst_act_data", |act_data_out, 0);
    chk("rst_inst_rdy", s_inst_rdy, 1);
    chk("rst_busy", row_busy, 0);
    act_data_out_req = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      s_act_data = 32'hA000_0000 + i;
      s_act_mask = 8'hFF;
      s_act_vld = 1'b1;
      if (i == 1) begin
        @(negedge clk_h);
        chk("bc_first_lane5", act_data_out[5*32 +: 32], 32'hA000_0000);
        chk("bc_first_vld", act_data_out_vld, 8'hFF);
      end
      tick();
    end
    s_act_mask = 8'h00;
    s_act_data = 32'h0000_DEAD;
    @(negedge clk_h);
    chk("zero_mask_rdy", s_act_rdy, 1);
    tick();
    s_act_vld = 1'b0;
    s_inst_mask = 8'h00;
    s_inst_vld = 1'b1;
    tick();
    s_inst_vld = 1'b0;
    @(negedge clk_h);
    chk("zero_inst_rdy", s_inst_rdy, 1);
    repeat (4) tick();
    act_data_out_req = 8'hF7;
    s_act_mask = 8'h08;
    s_act_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_act_data = 32'hB000_0000 + i;
      tick();
    end
    s_act_data = 32'hB000_0004;
    @(negedge clk_h);
    chk("bp_rdy_full", s_act_rdy, 0);
    tick();
    s_act_mask = 8'h01;
    s_act_data = 32'hC000_0000;
    @(negedge clk_h);
    chk("bp_other_lane_rdy", s_act_rdy, 1);
    tick();
    s_act_mask = 8'h08;
    s_act_data = 32'hB000_0004;
    tick();
    tick();
    act_data_out_req = 8'hFF;
    push_wait("bp_release");
    s_act_vld = 1'b0;
    repeat (6) tick();
    act_data_out_req = 8'hFD;
    s_act_mask = 8'h02;
    s_act_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_act_data = 32'h0D00_0000 + i;
      tick();
    end
    s_act_mask = 8'h03;
    s_act_data = 32'h0DD0_0000;
    @(negedge clk_h);
    chk("mc_blocked", s_act_rdy, 0);
    tick();
    tick();
    @(negedge clk_h);
    chk("mc_lane0_empty", act_data_out_vld[0], 0);
    tick();
    act_data_out_req = 8'hFF;
    push_wait("mc_release");
    s_act_vld = 1'b0;
    @(negedge clk_h);
    chk("mc_lane0_vld", act_data_out_vld[0], 1);
    chk("mc_lane0_data", act_data_out[31:0], 32'h0DD0_0000);
    repeat (6) tick();
    s_inst_data = 14'h1234;
    s_inst_mask = 8'h05;
    status_sblk = 8'h04;
    s_inst_vld = 1'b1;
    @(negedge clk_h);
    chk("stall_accept_rdy", s_inst_rdy, 1);
    tick();
    s_inst_vld = 1'b0;
    tick();
    tick();
    tick();
    status_sblk = 8'h00;
    @(negedge clk_h);
    chk("stall_no_en", inst_en_out, 0);
    tick();
    @(negedge clk_h);
    chk("stall_en", inst_en_out, 8'h05);
    chk("stall_data2", inst_data_out[2*14 +: 14], 14'h1234);
    chk("stall_perf", perf_inst_stall, PERF ? 32'd3 : 32'd0);
    tick();
    @(negedge clk_h);
    chk("stall_en_pulse", inst_en_out, 0);
    repeat (4) tick();
    done_cnt = 0;
    s_inst_data = 14'h3ABC;
    s_inst_mask = 8'h0F;
    s_inst_vld = 1'b1;
    tick();
    s_inst_vld = 1'b0;
    tick();
    status_sblk = 8'h0F;
    @(negedge clk_h);
    chk("cmp_en", inst_en_out, 8'h0F);
    tick();
    tick();
    status_sblk = 8'h0E;
    @(negedge clk_h);
    chk("cmp_busy_all", row_busy, 8'h0F);
    tick();
    status_sblk = 8'h0C;
    @(negedge clk_h);
    chk("cmp_busy_e", row_busy, 8'h0E);
    tick();
    status_sblk = 8'h00;
    @(negedge clk_h);
    chk("cmp_busy_c", row_busy, 8'h0C);
    tick();
    s_inst_vld = 1'b1;
    s_inst_mask = 8'h10;
    s_inst_data = 14'h0155;
    @(negedge clk_h);
    chk("cmp_done", all_done, 1);
    chk("cmp_busy_clear", row_busy, 0);
    chk("cmp_next_rdy", s_inst_rdy, 1);
    tick();
    s_inst_vld = 1'b0;
    @(negedge clk_h);
    chk("cmp_next_taken", s_inst_rdy, 0);
    chk("cmp_one_done", done_cnt, 1);
    repeat (6) tick();
    act_data_out_req = 8'h00;
    s_act_mask = 8'hFF;
    s_act_vld = 1'b1;
    s_act_data = 32'hE000_0000;
    tick();
    s_act_data = 32'hE000_0001;
    tick();
    s_act_vld = 1'b0;
    s_inst_mask = 8'h03;
    s_inst_data = 14'h02AA;
    s_inst_vld = 1'b1;
    tick();
    s_inst_vld = 1'b0;
    tick();
    status_sblk = 8'h03;
    tick();
    tick();
    @(negedge clk_h);
    chk("pre_rst_busy", row_busy, 8'h03);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk_h);
    chk("rst_mid_vld", act_data_out_vld, 0);
    chk("rst_mid_busy", row_busy, 0);
    chk("rst_mid_inst_rdy", s_inst_rdy, 1);
    chk("rst_mid_act_data", |act_data_out, 0);
    chk("rst_mid_inst_data", |inst_data_out, 0);
    status_sblk = 8'h00;
    act_data_out_req = 8'hFF;
    s_act_data = 32'hF000_0000;
    s_act_vld = 1'b1;
    tick();
    s_act_vld = 1'b0;
    @(negedge clk_h);
    chk("post_rst_vld", act_data_out_vld, 8'hFF);
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
